// File: rtl/spi_slave_ctrl_param.sv
// Mode-0, LSB-first SPI slave bridging an oversampled SPI link to a synchronous single-port RAM.
// Frame: 2-bit cmd, ADDR_W-bit address, then DATA_W-bit words (single or auto-increment burst).
module spi_slave_ctrl_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCK,
  input  logic              MOSI,
  input  logic              CS,
  input  logic [DATA_W-1:0] Data_in,
  output logic              MISO,
  output logic [DATA_W-1:0] Data_out,
  output logic [ADDR_W-1:0] Addr,
  output logic              WE,
  output logic              RE,
  output logic              Wrap,
  output logic              Busy
);

  localparam int HDR_BITS = ADDR_W + 2;
  localparam int MAX_BITS = (HDR_BITS > DATA_W) ? HDR_BITS : DATA_W;
  localparam int CNT_W    = $clog2(MAX_BITS + 1);

  typedef enum logic [2:0] {
    IDLE, HDR, RD_FETCH, RD_DATA, WR_DATA, WR_COMMIT, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        sck_sync_q, sck_sync_d;
  logic [1:0]        mosi_sync_q, mosi_sync_d;
  logic [2:0]        cs_sync_q, cs_sync_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              miso_q, miso_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              wrap_q, wrap_d;
  logic              busy_q, busy_d;

  logic sck_rise, mosi_s, cs_s, cs_fall;

  always_comb begin
    sck_sync_d  = {sck_sync_q[1:0], SCK};
    mosi_sync_d = {mosi_sync_q[0], MOSI};
    cs_sync_d   = {cs_sync_q[1:0], CS};
    sck_rise    = sck_sync_q[1] & ~sck_sync_q[2];
    mosi_s      = mosi_sync_q[1];
    cs_s        = cs_sync_q[1];
    cs_fall     = cs_sync_q[2] & ~cs_sync_q[1];

    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    shreg_d    = shreg_q;
    data_out_d = data_out_q;
    wrap_d     = wrap_q;
    we_d       = 1'b0;
    re_d       = 1'b0;

    if (cs_s) begin
      // Deselect aborts any frame; pending fetch or partial word is simply dropped.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_d = HDR;
            wrap_d  = 1'b0;
          end
        end
        HDR: begin
          if (sck_rise) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q < CNT_W'(2)) cmd_d[cnt_q[0]] = mosi_s;
            else addr_d = (addr_q >> 1) | (ADDR_W'(mosi_s) << (ADDR_W - 1));
            if (cnt_q == CNT_W'(HDR_BITS - 1)) begin
              if (cmd_d[1]) begin
                state_d = WR_DATA;
              end else begin
                state_d = RD_FETCH;
                re_d    = 1'b1;
              end
            end
          end
        end
        RD_FETCH: begin
          // Cycle 0 carries the RE pulse; RAM data is captured one cycle later.
          if (cnt_q == '0) begin
            cnt_d = CNT_W'(1);
          end else begin
            shreg_d = Data_in;
            state_d = RD_DATA;
          end
        end
        RD_DATA: begin
          if (sck_rise) begin
            cnt_d   = cnt_q + CNT_W'(1);
            shreg_d = {mosi_s, shreg_q[DATA_W-1:1]};
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              if (cmd_q[0]) begin
                addr_d  = addr_q + ADDR_W'(1);
                wrap_d  = wrap_q | (&addr_q);
                state_d = RD_FETCH;
                re_d    = 1'b1;
              end else begin
                state_d = DONE;
              end
            end
          end
        end
        WR_DATA: begin
          if (sck_rise) begin
            cnt_d   = cnt_q + CNT_W'(1);
            shreg_d = {mosi_s, shreg_q[DATA_W-1:1]};
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              state_d    = WR_COMMIT;
              data_out_d = shreg_d;
              we_d       = 1'b1;
            end
          end
        end
        WR_COMMIT: begin
          if (cmd_q[0]) begin
            addr_d  = addr_q + ADDR_W'(1);
            wrap_d  = wrap_q | (&addr_q);
            state_d = WR_DATA;
          end else begin
            state_d = DONE;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end

    if (state_d != state_q) cnt_d = '0;
    miso_d = (state_d == RD_DATA) ? shreg_d[0] : 1'b0;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '0;
      cnt_q       <= '0;
      cmd_q       <= '0;
      addr_q      <= '0;
      shreg_q     <= '0;
      data_out_q  <= '0;
      miso_q      <= 1'b0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      wrap_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sck_sync_q  <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_sync_q   <= cs_sync_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      shreg_q     <= shreg_d;
      data_out_q  <= data_out_d;
      miso_q      <= miso_d;
      we_q        <= we_d;
      re_q        <= re_d;
      wrap_q      <= wrap_d;
      busy_q      <= busy_d;
    end
  end

  assign MISO     = miso_q;
  assign Data_out = data_out_q;
  assign Addr     = addr_q;
  assign WE       = we_q;
  assign RE       = re_q;
  assign Wrap     = wrap_q;
  assign Busy     = busy_q;

endmodule

// File: tb/tb_spi_slave_ctrl_param.sv
// Bench for spi_slave_ctrl_param: SPI master driver, RAM model, RE/WE scoreboard and frame table.
module tb_spi_slave_ctrl_param;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int HALF   = 6;

  logic              clk, rst, sck, mosi, cs;
  logic [DATA_W-1:0] data_in;
  logic              miso;
  logic [DATA_W-1:0] data_out;
  logic [ADDR_W-1:0] addr;
  logic              we, re, wrap, busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [ADDR_W-1:0]        re_exp_q[$];
  logic [DATA_W-1:0]        ram [0:(1<<ADDR_W)-1];

  typedef struct {
    logic [1:0]        cmd;
    logic [ADDR_W-1:0] a;
    int                n;
    logic [DATA_W-1:0] w0, w1, w2;
    logic              exp_wrap;
  } vec_t;
  vec_t vecs [8];

  spi_slave_ctrl_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .SCK(sck), .MOSI(mosi), .CS(cs), .Data_in(data_in),
    .MISO(miso), .Data_out(data_out), .Addr(addr), .WE(we), .RE(re),
    .Wrap(wrap), .Busy(busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: read data appears one clk after RE
  always @(posedge clk) begin
    if (re) data_in <= ram[addr];
    if (we) ram[addr] <= data_out;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every RE/WE pulse must match the head of its expected queue
  always @(negedge clk) begin
    if (rst) begin
      if (we && re) check("re_we_overlap", 1, 0);
      if (we) begin
        if (exp_q.size() == 0) check("we_unexpected", {addr, data_out}, 0);
        else check("we_addr_data", {addr, data_out}, exp_q.pop_front());
      end
      if (re) begin
        if (re_exp_q.size() == 0) check("re_unexpected", addr, 0);
        else check("re_addr", addr, re_exp_q.pop_front());
      end
    end
  end

  // Driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic m);
    @(negedge clk);
    mosi = b;
    wait_clk(HALF - 1);
    m   = miso;
    sck = 1'b1;
    wait_clk(HALF);
    sck = 1'b0;
  endtask

  task automatic send_header(input logic [1:0] cmd, input logic [ADDR_W-1:0] a);
    logic m;
    spi_bit(cmd[0], m);
    spi_bit(cmd[1], m);
    for (int b = 0; b < ADDR_W; b++) spi_bit(a[b], m);
  endtask

  task automatic send_word(input logic [DATA_W-1:0] w, input int nbits, output logic [DATA_W-1:0] rx);
    logic m;
    rx = '0;
    for (int b = 0; b < nbits; b++) begin
      spi_bit(w[b], m);
      rx[b] = m;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_miso"}, miso, 0);
    check({tag, "_we"}, we, 0);
    check({tag, "_re"}, re, 0);
    check({tag, "_wrap"}, wrap, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_addr"}, addr, 0);
    check({tag, "_data_out"}, data_out, 0);
  endtask

  task automatic run_frame(input logic [1:0] cmd, input logic [ADDR_W-1:0] a, input int n,
                           input logic [DATA_W-1:0] w0, w1, w2, input logic exp_wrap);
    logic [DATA_W-1:0] tx [3];
    logic [DATA_W-1:0] rx;
    tx[0] = w0; tx[1] = w1; tx[2] = w2;
    if (cmd[1]) begin
      for (int k = 0; k < n; k++) exp_q.push_back({a + ADDR_W'(k), tx[k]});
    end else begin
      // A burst read prefetches one word beyond the last one clocked out
      for (int k = 0; k < n + int'(cmd[0]); k++) re_exp_q.push_back(a + ADDR_W'(k));
    end
    @(negedge clk);
    cs = 1'b0;
    wait_clk(HALF);
    check("wrap_clear_at_start", wrap, 0);
    send_header(cmd, a);
    for (int k = 0; k < n; k++) begin
      send_word(cmd[1] ? tx[k] : DATA_W'(0), DATA_W, rx);
      if (!cmd[1]) check("read_word", rx, tx[k]);
    end
    wait_clk(HALF);
    check("busy_in_frame", busy, 1);
    check("wrap_in_frame", wrap, exp_wrap);
    if (cmd != 2'b01) check("miso_idle_done", miso, 0);
    cs = 1'b1;
    wait_clk(HALF);
    check("busy_after_cs", busy, 0);
    check("miso_after_cs", miso, 0);
    check("wrap_held", wrap, exp_wrap);
    check("we_drained", exp_q.size(), 0);
    check("re_drained", re_exp_q.size(), 0);
  endtask

  task automatic set_vec(input int i, input logic [1:0] cmd, input logic [ADDR_W-1:0] a, input int n,
                         input logic [DATA_W-1:0] w0, w1, w2, input logic ew);
    vecs[i].cmd = cmd; vecs[i].a = a; vecs[i].n = n;
    vecs[i].w0 = w0; vecs[i].w1 = w1; vecs[i].w2 = w2; vecs[i].exp_wrap = ew;
  endtask

  initial begin
    logic [DATA_W-1:0] rx;
    logic m;

    set_vec(0, 2'b10, 5'h05, 1, 8'hA5, 8'h00, 8'h00, 1'b0);
    set_vec(1, 2'b00, 5'h12, 1, 8'h3C, 8'h00, 8'h00, 1'b0);
    set_vec(2, 2'b01, 5'h1E, 3, 8'h11, 8'h22, 8'h33, 1'b1);
    set_vec(3, 2'b11, 5'h03, 2, 8'h01, 8'h02, 8'h00, 1'b0);
    set_vec(4, 2'b01, 5'h03, 2, 8'h01, 8'h02, 8'h00, 1'b0);
    set_vec(5, 2'b00, 5'h05, 1, 8'hA5, 8'h00, 8'h00, 1'b0);
    set_vec(6, 2'b11, 5'h1F, 2, 8'h5A, 8'hC3, 8'h00, 1'b1);
    set_vec(7, 2'b01, 5'h1F, 2, 8'h5A, 8'hC3, 8'h00, 1'b1);

    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = '0;
    ram[5'h12] = 8'h3C;
    ram[5'h1E] = 8'h11;
    ram[5'h1F] = 8'h22;
    ram[5'h00] = 8'h33;
    data_in = '0;

    // Reset with CS already low: leaving reset must not start a frame
    rst = 1'b0; cs = 1'b0; sck = 1'b0; mosi = 1'b0;
    wait_clk(3);
    check_all_zero("reset");
    rst = 1'b1;
    wait_clk(10);
    check("no_start_cs_low", busy, 0);
    cs = 1'b1;
    wait_clk(HALF);

    for (int i = 0; i < 8; i++)
      run_frame(vecs[i].cmd, vecs[i].a, vecs[i].n, vecs[i].w0, vecs[i].w1, vecs[i].w2, vecs[i].exp_wrap);

    // CS abort after 5 data bits: no WE, Busy drops within 3 clk, next frame normal
    @(negedge clk);
    cs = 1'b0;
    wait_clk(HALF);
    send_header(2'b10, 5'h07);
    send_word(8'hFF, 5, rx);
    @(negedge clk);
    cs = 1'b1;
    wait_clk(3);
    check("abort_busy", busy, 0);
    wait_clk(HALF);
    check("abort_we_q", exp_q.size(), 0);
    run_frame(2'b10, 5'h07, 1, 8'h77, 8'h00, 8'h00, 1'b0);
    run_frame(2'b00, 5'h07, 1, 8'h77, 8'h00, 8'h00, 1'b0);

    // Reset in the middle of a wrapping burst write, CS held low throughout
    exp_q.push_back({5'h1E, 8'h44});
    exp_q.push_back({5'h1F, 8'h55});
    exp_q.push_back({5'h00, 8'h66});
    @(negedge clk);
    cs = 1'b0;
    wait_clk(HALF);
    send_header(2'b11, 5'h1E);
    send_word(8'h44, DATA_W, rx);
    send_word(8'h55, DATA_W, rx);
    send_word(8'h66, DATA_W, rx);
    send_word(8'h99, 3, rx);
    wait_clk(2);
    check("pre_reset_wrap", wrap, 1);
    check("pre_reset_addr", addr, 5'h01);
    @(negedge clk);
    rst = 1'b0;
    wait_clk(2);
    check_all_zero("mid_reset");
    rst = 1'b1;
    for (int b = 0; b < 15; b++) spi_bit(b[0], m);
    wait_clk(HALF);
    check("post_reset_busy", busy, 0);
    check("post_reset_wrap", wrap, 0);
    check("post_reset_we_q", exp_q.size(), 0);
    cs = 1'b1;
    wait_clk(HALF);
    run_frame(2'b01, 5'h1E, 3, 8'h44, 8'h55, 8'h66, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety bound on total runtime
  initial begin
    #2000000;
    $display("FAIL timeout: got 0x1, expected 0x0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spi_slave_ctrl_param.md
# spi_slave_ctrl_param

Parametrised SPI slave (mode 0, LSB-first) that bridges an external SPI master to a synchronous single-port RAM on the system clock. Each frame carries a 2-bit command, an ADDR_W-bit address and one or more DATA_W-bit words. It supports single and auto-increment (burst) reads and writes, with address wrap reporting. SCK, MOSI and CS are oversampled on `clk`, so the whole block lives in one clock domain.

## Interface
- DATA_W, 8, data word width (≥2)
- ADDR_W, 5, RAM address width (≥1)
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- SCK  in  1  SPI serial clock, asynchronous to clk
- MOSI  in  1  SPI data in
- CS  in  1  chip select, active-low
- Data_in  in  DATA_W  RAM read data, valid 1 clk after RE
- MISO  out  1  SPI data out
- Data_out  out  DATA_W  RAM write data, valid while WE=1
- Addr  out  ADDR_W  RAM address
- WE  out  1  RAM write strobe, 1-clk pulse
- RE  out  1  RAM read strobe, 1-clk pulse
- Wrap  out  1  address wrapped during current burst
- Busy  out  1  frame in progress (state ≠ IDLE)

## Operation
- SCK, MOSI and CS each pass through a 2-flop synchroniser. A third SCK flop gives rise/fall detect. Only synchronised values are used internally.
- Frame start: the synchronised CS goes 1→0 while in IDLE. CS already low when leaving reset does not start a frame; a frame needs a 1→0 edge.
- Bit order: LSB first throughout. First two bits form cmd[0], cmd[1]. The next ADDR_W bits form addr[0]..addr[ADDR_W-1]. Data words follow.
- Commands: 00 single read, 01 burst read, 10 single write, 11 burst write.
- One DATA_W shift register serves both directions. On each sampled SCK rise in a data state: shreg <= {MOSI, shreg[DATA_W-1:1]}. MISO = shreg[0] in RD_DATA, otherwise 0.
- State machine:
  - IDLE → HDR on CS fall.
  - HDR: shift in cmd and address. After bit ADDR_W+2: cmd[1]=0 → RD_FETCH, cmd[1]=1 → WR_DATA.
  - RD_FETCH: RE=1 for 1 clk. The next clk loads shreg <= Data_in, then → RD_DATA.
  - RD_DATA: after DATA_W rises, burst → Addr+1, then RD_FETCH; single → DONE.
  - WR_DATA: after DATA_W rises → WR_COMMIT.
  - WR_COMMIT: Data_out <= shreg, WE=1 for 1 clk. Next clk: burst → Addr+1, then WR_DATA; single → DONE.
  - DONE: ignore SCK, MISO=0, wait for CS high → IDLE.
- Synchronised CS high in any state → IDLE next clk.
  - A partial write word produces no WE.
  - A pending RD_FETCH load is discarded.
- Address increment is modulo 2^ADDR_W. An increment from all-ones to 0 sets Wrap. Wrap clears on the next frame start and on reset.
- Bit counter width is clog2(max(ADDR_W+2, DATA_W)+1). It clears on every state change.

## Timing
- Reset (rst=0 at a clk edge) clears everything. State=IDLE. MISO, WE, RE, Wrap, Busy = 0. Addr, Data_out, shreg = 0.
- Reset mid-frame aborts with no WE. The next frame requires a new CS fall.
- SCK high and low phases must each be ≥4 clk. CS setup to the first SCK rise must be ≥4 clk.
- A sampled SCK edge acts internally 3 clk after the pin edge. This meets mode-0 hold because MISO changes after the master samples.
- Read path latency:
  - RE asserts 1 clk after the internal sample of the last address bit (burst: of the last word bit, after Addr+1).
  - Data_in is captured 1 clk after RE. MISO is valid ≥2 clk before the next SCK rise.
- Write: WE asserts 1 clk after the internal sample of the final word bit. Addr and Data_out are stable while WE=1. Burst Addr updates the clk after WE.
- RE and WE never both high. Each is at most one pulse per word.

## Test plan
- Single write (DATA_W=8, ADDR_W=5): cmd=10, addr=0x05, data=0xA5 → exactly one WE pulse with Addr=0x05, Data_out=0xA5. RE never asserts. DONE until CS high.
- Single read: cmd=00, addr=0x12, RAM[0x12]=0x3C → one RE with Addr=0x12. Master receives 0x3C LSB-first on MISO. MISO=0 after.
- Burst read wrap: cmd=01, addr=0x1E, 3 words, RAM model 0x11/0x22/0x33 at 0x1E/0x1F/0x00 → RE at Addr 0x1E, 0x1F, 0x00. Data 11,22,33 returned. Wrap=1 from the increment to 0x00 until the next CS fall.
- Burst write: cmd=11, addr=0x03, words 0x01,0x02 → WE at 0x03 (Data_out=0x01), then at 0x04 (Data_out=0x02).
- CS abort: cmd=10, addr=0x07, CS high after 5 data bits → no WE. Busy=0 within 3 clk. The next full frame works normally.
- Reset mid-frame: rst low during a burst write with CS held low → all outputs 0. No activity until CS goes high then low.
